// File: rtl/pc_imem_pkg.sv
// pc_imem_pkg: shared ROM image, MIPS field positions and NOP word for pc_imem.
package pc_imem_pkg;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int IMAGE_WORDS = 16;
  localparam logic [0:IMAGE_WORDS-1][31:0] ROM_IMAGE = {
    32'h2008_0005, 32'h2009_000A, 32'h0109_5020, 32'h0128_5822,
    32'h0109_6024, 32'h0109_6825, 32'hAC0A_0000, 32'h8C0E_0000,
    32'h110A_0001, 32'h0000_0000, {6{NOP}}
  };
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
endpackage

// File: rtl/imem_rom.sv
// imem_rom: combinational read-only instruction memory, NOP beyond DEPTH.
module imem_rom
  import pc_imem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic [29:0] word_addr,
  output logic [31:0] data
);
  logic [31:0] idx;
  assign idx = {2'b00, word_addr};
  assign data = (idx < 32'(DEPTH) && idx < 32'(IMAGE_WORDS)) ? ROM_IMAGE[idx[3:0]] : NOP;
endmodule

// File: rtl/pc_reg.sv
// pc_reg: 32-bit program counter with load enable and async active-low reset.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= RESET_PC;
    else if (en) q <= d;
endmodule

// File: rtl/pc_imem.sv
// pc_imem: program counter feeding a fixed instruction ROM with MIPS field decode.
module pc_imem
  import pc_imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic [31:0] next_pc,
  output logic [31:0] current_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instruction,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] imm_sext
);
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .reset(reset), .en(pc_en), .d(next_pc), .q(current_pc)
  );
  // Byte offset bits are dropped: the ROM is word-addressed.
  imem_rom #(.DEPTH(DEPTH)) u_rom (
    .word_addr(current_pc[31:2]), .data(instruction)
  );
  assign pc_plus4 = current_pc + 32'd4;
  assign opcode   = instruction[OPCODE_MSB:OPCODE_LSB];
  assign rs       = instruction[RS_MSB:RS_LSB];
  assign rt       = instruction[RT_MSB:RT_LSB];
  assign rd       = instruction[RD_MSB:RD_LSB];
  assign shamt    = instruction[SHAMT_MSB:SHAMT_LSB];
  assign funct    = instruction[FUNCT_MSB:FUNCT_LSB];
  assign imm      = instruction[IMM_MSB:IMM_LSB];
  assign imm_sext = {{16{instruction[IMM_MSB]}}, instruction[IMM_MSB:IMM_LSB]};
endmodule

// File: tb/tb_pc_imem.sv
// tb_pc_imem: table-driven directed checks of pc_imem plus reset corner sequences.
module tb_pc_imem;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_en = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic [31:0] current_pc, pc_plus4, instruction, imm_sext;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [31:0] npc;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;
  vec_t vecs[$];

  pc_imem dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .next_pc(next_pc),
    .current_pc(current_pc), .pc_plus4(pc_plus4), .instruction(instruction),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm(imm), .imm_sext(imm_sext)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [31:0] npc);
    pc_en = en;
    next_pc = npc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{1'b1, 32'h00, 32'h00, 32'h2008_0005});
    vecs.push_back('{1'b1, 32'h04, 32'h04, 32'h2009_000A});
    vecs.push_back('{1'b1, 32'h08, 32'h08, 32'h0109_5020});
    vecs.push_back('{1'b1, 32'h0C, 32'h0C, 32'h0128_5822});
    vecs.push_back('{1'b1, 32'h10, 32'h10, 32'h0109_6024});
    vecs.push_back('{1'b1, 32'h14, 32'h14, 32'h0109_6825});
    vecs.push_back('{1'b1, 32'h18, 32'h18, 32'hAC0A_0000});
    vecs.push_back('{1'b1, 32'h1C, 32'h1C, 32'h8C0E_0000});
    vecs.push_back('{1'b1, 32'h14, 32'h14, 32'h0109_6825});
    vecs.push_back('{1'b0, 32'h100, 32'h14, 32'h0109_6825});
    vecs.push_back('{1'b0, 32'h200, 32'h14, 32'h0109_6825});
    vecs.push_back('{1'b0, 32'h300, 32'h14, 32'h0109_6825});
    vecs.push_back('{1'b1, 32'h06, 32'h06, 32'h2009_000A});
    vecs.push_back('{1'b1, 32'h23, 32'h23, 32'h110A_0001});
    vecs.push_back('{1'b1, 32'hFC, 32'hFC, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'h100, 32'h100, 32'h0000_0000});
    vecs.push_back('{1'b1, 32'h400, 32'h400, 32'h0000_0000});

    #12;
    check("rst_pc", current_pc, 32'h0);
    check("rst_instr", instruction, 32'h2008_0005);
    check("rst_opcode", {26'h0, opcode}, 32'h08);
    check("rst_rt", {27'h0, rt}, 32'h8);
    check("rst_imm", {16'h0, imm}, 32'h0005);
    check("rst_imm_sext", imm_sext, 32'h0000_0005);
    check("rst_plus4", pc_plus4, 32'h4);
    pc_en = 1'b1;
    next_pc = 32'h40;
    @(posedge clk);
    #1;
    check("rst_held_pc", current_pc, 32'h0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].npc);
      check($sformatf("vec%0d_pc", i), current_pc, vecs[i].pc);
      check($sformatf("vec%0d_instr", i), instruction, vecs[i].ins);
      check($sformatf("vec%0d_plus4", i), pc_plus4, vecs[i].pc + 32'd4);
    end

    step(1'b1, 32'h08);
    check("add_opcode", {26'h0, opcode}, 32'h0);
    check("add_rs", {27'h0, rs}, 32'd8);
    check("add_rt", {27'h0, rt}, 32'd9);
    check("add_rd", {27'h0, rd}, 32'd10);
    check("add_shamt", {27'h0, shamt}, 32'd0);
    check("add_funct", {26'h0, funct}, 32'd32);
    step(1'b1, 32'h0C);
    check("sub_funct", {26'h0, funct}, 32'd34);
    step(1'b1, 32'h20);
    check("beq_imm_sext", imm_sext, 32'h0000_0001);
    check("beq_opcode", {26'h0, opcode}, 32'h04);

    step(1'b1, 32'hFFFF_FFFC);
    check("wrap_pc", current_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0);
    check("wrap_instr", instruction, 32'h0);

    step(1'b1, 32'h1C);
    check("pre_async_pc", current_pc, 32'h1C);
    pc_en = 1'b1;
    next_pc = 32'h40;
    #2;
    reset = 1'b0;
    #1;
    check("async_pc", current_pc, 32'h0);
    check("async_instr", instruction, 32'h2008_0005);
    @(posedge clk);
    #1;
    check("async_hold_pc", current_pc, 32'h0);
    reset = 1'b1;
    step(1'b1, 32'h20);
    check("post_rst_pc", current_pc, 32'h20);
    check("post_rst_instr", instruction, 32'h110A_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
